// File: rtl/switch_debouncer_if.sv
// Change-event channel of the switch debouncer.
//   EVT_VALID   : change event pending, held until acknowledged
//   EVT_DATA    : debounced switch snapshot belonging to the pending event
//   EVT_OVERRUN : a further change landed while the event was unacknowledged
//   EVT_ACK     : consumer acknowledge, only meaningful while EVT_VALID is 1
// master = debouncer (event source), slave = consumer.
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic             EVT_VALID;
  logic [WIDTH-1:0] EVT_DATA;
  logic             EVT_OVERRUN;
  logic             EVT_ACK;

  modport master (
    output EVT_VALID, EVT_DATA, EVT_OVERRUN,
    input  EVT_ACK
  );

  modport slave (
    input  EVT_VALID, EVT_DATA, EVT_OVERRUN,
    output EVT_ACK
  );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser plus stability-counter
// debounce per bit, registered rise/fall pulses and a held change event.
//   CLK100MHZ : sole clock, rising edge
//   RESET     : synchronous, active-high
//   SW        : raw asynchronous switch inputs
//   SW_DB     : debounced levels
//   SW_RISE   : one-cycle pulse per bit on a debounced 0->1 change
//   SW_FALL   : one-cycle pulse per bit on a debounced 1->0 change
//   evt       : change-event channel (valid/ack, snapshot, overrun)

// One switch channel: synchroniser, stability counter, debounced level.
//   sw_raw : raw pin     db : debounced level
//   rise/fall : registered edge pulses
//   upd : combinational, high on the edge where db takes the new value
module switch_debouncer_chan #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic CLK100MHZ,
  input  logic RESET,
  input  logic sw_raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic upd
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  // The counter clears on any match, so reaching CNT_LAST while still
  // mismatching means STABLE_CYCLES consecutive disagreeing samples.
  assign upd = (sync2 != db) && (cnt == CNT_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (upd) begin
        cnt <= '0;
        db  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      rise <= upd &  sync2;
      fall <= upd & ~sync2;
    end
  end
endmodule

module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic             CLK100MHZ,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  switch_debouncer_if.master evt
);
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] db_nxt;
  logic             upd_any;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    switch_debouncer_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .CLK100MHZ (CLK100MHZ),
      .RESET     (RESET),
      .sw_raw    (SW[g]),
      .db        (SW_DB[g]),
      .rise      (SW_RISE[g]),
      .fall      (SW_FALL[g]),
      .upd       (upd[g])
    );
  end

  // An update always flips the bit, so the post-edge level is a simple XOR;
  // this lets the event snapshot load on the same edge as SW_DB.
  assign db_nxt  = SW_DB ^ upd;
  assign upd_any = |upd;

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      evt.EVT_VALID   <= 1'b0;
      evt.EVT_DATA    <= '0;
      evt.EVT_OVERRUN <= 1'b0;
    end else if (upd_any) begin
      evt.EVT_VALID <= 1'b1;
      evt.EVT_DATA  <= db_nxt;
      // Unacknowledged pending event gets overwritten (latest wins);
      // an ack on the same edge consumes it, so the fresh event is clean.
      if (evt.EVT_VALID)
        evt.EVT_OVERRUN <= ~evt.EVT_ACK;
    end else if (evt.EVT_VALID && evt.EVT_ACK) begin
      evt.EVT_VALID   <= 1'b0;
      evt.EVT_OVERRUN <= 1'b0;
    end
  end
endmodule
